// File: rtl/gray_frame_packer.sv
// rtl/gray_frame_packer.sv - raster-tracking 4:1 pixel packer with flagged FWFT output FIFO
// Consumes a valid-qualified 8-bit raster stream, emits 32-bit words tagged sof/eol/eof.
module gray_frame_packer #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_in_valid,
    input  logic [7:0]  pixel_in,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_data,
    output logic        word_sof,
    output logic        word_eol,
    output logic        word_eof,
    output logic        frame_done,
    output logic        overflow
);

    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST_WORD_END = CW'(3);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [23:0]   hold_q, hold_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          frame_done_q, frame_done_d;

    // Entry layout: [34] sof, [33] eol, [32] eof, [31:0] packed pixels.
    logic [34:0]   mem [FIFO_DEPTH];
    logic [34:0]   wr_entry;
    logic [34:0]   rd_entry;

    logic col_last;
    logic row_last;
    logic word_done;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    always_comb begin
        col_last   = (col_q == COL_LAST);
        row_last   = (row_q == ROW_LAST);
        word_done  = pixel_in_valid && (col_q[1:0] == 2'b11);
        wr_entry   = {(row_q == '0) && (col_q == COL_FIRST_WORD_END),
                      col_last,
                      col_last && row_last,
                      pixel_in, hold_q};
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        pop        = !fifo_empty && word_ready;
        // A full FIFO still accepts a word when the head leaves on the same edge.
        push       = word_done && (!fifo_full || pop);
        rd_entry   = mem[rd_ptr_q];
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        frame_done_d = pop && rd_entry[32];

        if (pixel_in_valid) begin
            hold_d = {pixel_in, hold_q[23:8]};
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (word_done && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // Word outputs read as zero when empty so stale entries never leak out.
    always_comb begin
        word_valid = !fifo_empty;
        word_data  = fifo_empty ? 32'd0 : rd_entry[31:0];
        word_sof   = !fifo_empty && rd_entry[34];
        word_eol   = !fifo_empty && rd_entry[33];
        word_eof   = !fifo_empty && rd_entry[32];
        frame_done = frame_done_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_gray_frame_packer.sv
// tb/tb_gray_frame_packer.sv - randomized and directed scoreboard bench for gray_frame_packer
module tb_gray_frame_packer;

    localparam int W = 8;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pixel_in_valid = 1'b0;
    logic [7:0]  pixel_in = 8'd0;
    logic        word_ready = 1'b0;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_sof;
    logic        word_eol;
    logic        word_eof;
    logic        frame_done;
    logic        overflow;

    always #5 clk = ~clk;

    gray_frame_packer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .FIFO_DEPTH  (D)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixel_in_valid(pixel_in_valid),
        .pixel_in      (pixel_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .word_data     (word_data),
        .word_sof      (word_sof),
        .word_eol      (word_eol),
        .word_eof      (word_eof),
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } wrd_t;

    wrd_t       mq[$];
    wrd_t       sb[$];
    logic [7:0] grp[$];
    int         pos;
    logic       exp_ovf;
    logic       exp_fd;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: raster position from a pixel index, FIFO as a bounded queue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            grp.delete();
            pos = 0;
            exp_ovf = 1'b0;
            exp_fd = 1'b0;
        end else begin
            wrd_t w;
            bit   had_room;
            bit   popped;
            int   col;
            int   row;
            had_room = (mq.size() < D);
            popped   = (mq.size() > 0) && word_ready;
            exp_fd   = 1'b0;
            if (popped) begin
                w = mq.pop_front();
                exp_fd = w.eof;
            end
            if (pixel_in_valid) begin
                col = pos % W;
                row = pos / W;
                grp.push_back(pixel_in);
                if (col % 4 == 3) begin
                    w.data = {grp[3], grp[2], grp[1], grp[0]};
                    w.sof  = (row == 0) && (col == 3);
                    w.eol  = (col == W - 1);
                    w.eof  = w.eol && (row == H - 1);
                    grp.delete();
                    if (had_room || popped) begin
                        mq.push_back(w);
                        sb.push_back(w);
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
                pos = (pos + 1) % (W * H);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_word_valid", 32'(word_valid), 32'd0);
            chk("rst_word_data", word_data, 32'd0);
            chk("rst_word_sof", 32'(word_sof), 32'd0);
            chk("rst_word_eol", 32'(word_eol), 32'd0);
            chk("rst_word_eof", 32'(word_eof), 32'd0);
            chk("rst_frame_done", 32'(frame_done), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
        end else begin
            chk("word_valid", 32'(word_valid), 32'(mq.size() > 0));
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            if (word_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    chk("word_data", word_data, sb[0].data);
                    chk("word_sof", 32'(word_sof), 32'(sb[0].sof));
                    chk("word_eol", 32'(word_eol), 32'(sb[0].eol));
                    chk("word_eof", 32'(word_eof), 32'(sb[0].eof));
                    if (word_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] v);
        pixel_in_valid = 1'b1;
        pixel_in = v;
        @(posedge clk);
        #1;
        pixel_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        // Ramp frame, continuous, always ready.
        word_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i));
        idle(4);

        // Sparse: one valid then four idle.
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            idle(4);
        end

        // Backpressure for the first three words.
        word_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(8'(i));
        idle(3);
        word_ready = 1'b1;
        for (int i = 12; i < 16; i++) send(8'(i));
        idle(6);

        // Overflow: six words into a four-deep FIFO, then recover raster.
        word_ready = 1'b0;
        for (int i = 0; i < 24; i++) send(8'(i));
        idle(2);
        word_ready = 1'b1;
        idle(8);
        for (int i = 24; i < 32; i++) send(8'(i));
        for (int i = 0; i < 16; i++) send(8'(i));
        idle(4);

        // Reset mid-frame, then a fresh ramp.
        for (int i = 0; i < 6; i++) send(8'(100 + i));
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i));
        idle(4);

        // Full FIFO with a pop coinciding with a word completion.
        word_ready = 1'b0;
        for (int i = 0; i < 19; i++) send(8'(i + 32));
        word_ready = 1'b1;
        send(8'd51);
        word_ready = 1'b0;
        idle(3);
        word_ready = 1'b1;
        idle(8);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            pixel_in_valid = ($urandom % 4) != 0;
            pixel_in = 8'($urandom);
            word_ready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        pixel_in_valid = 1'b0;
        word_ready = 1'b1;
        idle(12);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
